// File: rtl/db15_pkg.sv
// Shared constants, state encoding and frame packing for the DB15 joystick transmitter.
package db15_pkg;

    localparam int unsigned FRAME_BITS  = 32;
    localparam int unsigned PLAYER_BITS = 16;
    localparam int unsigned BTN_BITS    = 12;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } db15_state_t;

    localparam int unsigned BTN_R      = 0;
    localparam int unsigned BTN_L      = 1;
    localparam int unsigned BTN_D      = 2;
    localparam int unsigned BTN_U      = 3;
    localparam int unsigned BTN_A      = 4;
    localparam int unsigned BTN_B      = 5;
    localparam int unsigned BTN_C      = 6;
    localparam int unsigned BTN_X      = 7;
    localparam int unsigned BTN_Y      = 8;
    localparam int unsigned BTN_Z      = 9;
    localparam int unsigned BTN_START  = 10;
    localparam int unsigned BTN_SELECT = 11;

    // Active-high frame word; the unused top bits of each player word read as released.
    function automatic logic [FRAME_BITS-1:0] frame_word(
        input logic [BTN_BITS-1:0] p1,
        input logic [BTN_BITS-1:0] p2
    );
        return {{(PLAYER_BITS-BTN_BITS){1'b0}}, p2,
                {(PLAYER_BITS-BTN_BITS){1'b0}}, p1};
    endfunction

endpackage

// File: rtl/db15_debounce.sv
// Single-input debouncer: the accepted level flips only after the raw level
// has differed from it for DEBOUNCE_CYC consecutive cycles.
module db15_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (raw == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/db15_joy_tx.sv
// DB15 joystick link transmitter: emulates the receiver-facing 74HC165 shift chain.
// Optional button debouncing is enabled with the DB15_TX_DEBOUNCE_EN macro.
module db15_joy_tx
    import db15_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 4096
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [BTN_BITS-1:0] p1_btn,
    input  logic [BTN_BITS-1:0] p2_btn,
    input  logic                joy_clk,
    input  logic                joy_load,
    output logic                joy_data,
    output logic                frame_done,
    output logic                err_short,
    output logic                err_overrun
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    logic [2*BTN_BITS-1:0] btn_meta_q, btn_meta_d;
    logic [2*BTN_BITS-1:0] btn_sync_q, btn_sync_d;
    logic [2*BTN_BITS-1:0] btn_db;

    logic clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d, clk_hist_q, clk_hist_d;
    logic load_meta_q, load_meta_d, load_sync_q, load_sync_d, load_hist_q, load_hist_d;

    db15_state_t           state_q, state_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  frame_done_q, frame_done_d;
    logic                  err_short_q, err_short_d;
    logic                  err_overrun_q, err_overrun_d;

    logic                  clk_rise;
    logic                  load_fall;
    logic [FRAME_BITS-1:0] frame;

`ifdef DB15_TX_DEBOUNCE_EN
    for (genvar i = 0; i < 2*BTN_BITS; i++) begin : g_deb
        db15_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (btn_sync_q[i]),
            .level  (btn_db[i])
        );
    end
`else
    assign btn_db = btn_sync_q;
`endif

    assign clk_rise  = clk_sync_q & ~clk_hist_q;
    assign load_fall = ~load_sync_q & load_hist_q;
    assign frame     = frame_word(btn_db[BTN_BITS-1:0], btn_db[2*BTN_BITS-1:BTN_BITS]);

    always_comb begin
        btn_meta_d  = {p2_btn, p1_btn};
        btn_sync_d  = btn_meta_q;
        clk_meta_d  = joy_clk;
        clk_sync_d  = clk_meta_q;
        clk_hist_d  = clk_sync_q;
        load_meta_d = joy_load;
        load_sync_d = load_meta_q;
        load_hist_d = load_sync_q;
    end

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        frame_done_d  = 1'b0;
        err_short_d   = 1'b0;
        err_overrun_d = 1'b0;

        // Load low keeps the register transparent and masks any clock edge seen with it.
        if (!load_sync_q) begin
            sr_d      = ~frame;
            bit_cnt_d = '0;
            if (load_fall) begin
                if (state_q == SHIFT && bit_cnt_q != '0) begin
                    err_short_d = 1'b1;
                end
                state_d = SHIFT;
            end
        end else if (clk_rise) begin
            case (state_q)
                SHIFT: begin
                    sr_d = {1'b1, sr_q[FRAME_BITS-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d      = DONE;
                        bit_cnt_d    = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                DONE:    err_overrun_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta_q    <= '0;
            btn_sync_q    <= '0;
            clk_meta_q    <= 1'b1;
            clk_sync_q    <= 1'b1;
            clk_hist_q    <= 1'b1;
            load_meta_q   <= 1'b1;
            load_sync_q   <= 1'b1;
            load_hist_q   <= 1'b1;
            state_q       <= IDLE;
            sr_q          <= '1;
            bit_cnt_q     <= '0;
            frame_done_q  <= 1'b0;
            err_short_q   <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            btn_meta_q    <= btn_meta_d;
            btn_sync_q    <= btn_sync_d;
            clk_meta_q    <= clk_meta_d;
            clk_sync_q    <= clk_sync_d;
            clk_hist_q    <= clk_hist_d;
            load_meta_q   <= load_meta_d;
            load_sync_q   <= load_sync_d;
            load_hist_q   <= load_hist_d;
            state_q       <= state_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_done_q  <= frame_done_d;
            err_short_q   <= err_short_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign joy_data    = (state_q == SHIFT) ? sr_q[0] : 1'b1;
    assign frame_done  = frame_done_q;
    assign err_short   = err_short_q;
    assign err_overrun = err_overrun_q;

endmodule
